spi_slave_bus_bridge: RTL and testbench

- Generalised bridge between the SPI slave frame decoder and the internal register bus.
- Converts decoded frames into register-bus write/read bursts with a configurable address stride.
- Buffers read data in an internal parametrised FIFO.
- Adds flow-controlled read issue, read timeout with filler data, frame-abort handling and sticky error flags.

---
 rtl/spi_slave_bus_bridge.sv | 206 ++++++++++++++++++++
 tb/tb_spi_slave_bus_bridge.sv | 333 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_slave_bus_bridge.sv
// rtl/spi_slave_bus_bridge.sv - SPI frame to register-bus bridge
// Write/read bursts with address stride, read FIFO, flow control, timeout and sticky errors.
module spi_slave_bus_bridge #(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 16,
   parameter int CMD_WIDTH  = 8,
   parameter int ADDR_STEP  = 4,
   parameter int FIFO_DEPTH = 16,
   parameter int RD_TIMEOUT = 255,
   parameter logic [DATA_WIDTH-1:0] FILL_DATA = DATA_WIDTH'(32'hDEAD_BEEF)
) (
   input  logic                  clk_i,
   input  logic                  rst_i,
   input  logic                  frm_start_i,
   input  logic [CMD_WIDTH-1:0]  frm_cmd_i,
   input  logic [ADDR_WIDTH-1:0] frm_addr_i,
   input  logic                  frm_wr_vld_i,
   input  logic [DATA_WIDTH-1:0] frm_wr_data_i,
   input  logic                  frm_rd_seq_i,
   output logic [DATA_WIDTH-1:0] frm_rd_data_o,
   output logic                  frm_rd_empty_o,
   output logic                  bus_wr_en_o,
   output logic                  bus_rd_en_o,
   output logic [ADDR_WIDTH-1:0] bus_addr_o,
   output logic [DATA_WIDTH-1:0] bus_wr_data_o,
   input  logic                  bus_rd_vld_i,
   input  logic [DATA_WIDTH-1:0] bus_rd_data_i,
   output logic                  busy_o,
   output logic                  err_timeout_o,
   output logic                  err_underflow_o,
   input  logic                  err_clr_i
);

   localparam int PW = $clog2(FIFO_DEPTH);
   localparam int CW = PW + 1;
   localparam int TW = $clog2(RD_TIMEOUT + 1);

   typedef enum logic [1:0] {ST_IDLE, ST_WR, ST_RD_ISSUE, ST_RD_WAIT} state_t;

   state_t                state_q, state_d;
   logic [ADDR_WIDTH-1:0] addr_q, addr_d;
   logic [CMD_WIDTH-1:0]  len_q, len_d;
   logic [CMD_WIDTH-1:0]  issued_q, issued_d;
   logic [TW-1:0]         tmo_q, tmo_d;
   logic                  wr_en_q, wr_en_d;
   logic                  rd_en_q, rd_en_d;
   logic [ADDR_WIDTH-1:0] bus_addr_q, bus_addr_d;
   logic [DATA_WIDTH-1:0] wr_data_q, wr_data_d;
   logic [PW-1:0]         wptr_q, wptr_d;
   logic [PW-1:0]         rptr_q, rptr_d;
   logic [CW-1:0]         cnt_q, cnt_d;
   logic [DATA_WIDTH-1:0] rd_data_q, rd_data_d;
   logic                  empty_q, empty_d;
   logic                  err_to_q, err_to_d;
   logic                  err_uf_q, err_uf_d;
   logic [DATA_WIDTH-1:0] mem_q [FIFO_DEPTH];

   logic                  push;
   logic [DATA_WIDTH-1:0] push_data;
   logic                  timeout_hit;
   logic                  pop_ok;

   always_comb begin
      state_d     = state_q;
      addr_d      = addr_q;
      len_d       = len_q;
      issued_d    = issued_q;
      tmo_d       = tmo_q;
      wr_en_d     = 1'b0;
      rd_en_d     = 1'b0;
      bus_addr_d  = bus_addr_q;
      wr_data_d   = wr_data_q;
      push        = 1'b0;
      push_data   = bus_rd_data_i;
      timeout_hit = 1'b0;
      if (frm_start_i) begin
         // A new frame always wins: abandon whatever burst or outstanding read was in flight.
         state_d  = frm_cmd_i[CMD_WIDTH-1] ? ST_RD_ISSUE : ST_WR;
         addr_d   = frm_addr_i;
         len_d    = {1'b0, frm_cmd_i[CMD_WIDTH-2:0]} + CMD_WIDTH'(1);
         issued_d = '0;
         tmo_d    = '0;
      end else begin
         case (state_q)
            ST_WR: begin
               if (frm_wr_vld_i) begin
                  wr_en_d    = 1'b1;
                  bus_addr_d = addr_q;
                  wr_data_d  = frm_wr_data_i;
                  addr_d     = addr_q + ADDR_WIDTH'(ADDR_STEP);
               end
            end
            ST_RD_ISSUE: begin
               if (cnt_q < CW'(FIFO_DEPTH)) begin
                  rd_en_d    = 1'b1;
                  bus_addr_d = addr_q;
                  tmo_d      = '0;
                  issued_d   = issued_q + CMD_WIDTH'(1);
                  state_d    = ST_RD_WAIT;
               end
            end
            ST_RD_WAIT: begin
               timeout_hit = !bus_rd_vld_i && (tmo_q == TW'(RD_TIMEOUT - 1));
               if (bus_rd_vld_i || timeout_hit) begin
                  push      = 1'b1;
                  push_data = bus_rd_vld_i ? bus_rd_data_i : FILL_DATA;
                  if (issued_q == len_q) begin
                     state_d = ST_IDLE;
                  end else begin
                     addr_d  = addr_q + ADDR_WIDTH'(ADDR_STEP);
                     state_d = ST_RD_ISSUE;
                  end
               end else begin
                  tmo_d = tmo_q + TW'(1);
               end
            end
            default: ;
         endcase
      end
   end

   always_comb begin
      pop_ok    = frm_rd_seq_i && (cnt_q != '0);
      wptr_d    = wptr_q;
      rptr_d    = rptr_q;
      cnt_d     = cnt_q;
      rd_data_d = rd_data_q;
      err_to_d  = (err_to_q & ~err_clr_i) | timeout_hit;
      err_uf_d  = err_uf_q & ~err_clr_i;
      if (frm_rd_seq_i) begin
         if (cnt_q != '0) begin
            rd_data_d = mem_q[rptr_q];
         end else begin
            rd_data_d = FILL_DATA;
            err_uf_d  = 1'b1;
         end
      end
      if (frm_start_i) begin
         wptr_d = '0;
         rptr_d = '0;
         cnt_d  = '0;
      end else begin
         if (push)   wptr_d = wptr_q + PW'(1);
         if (pop_ok) rptr_d = rptr_q + PW'(1);
         case ({push, pop_ok})
            2'b10:   cnt_d = cnt_q + CW'(1);
            2'b01:   cnt_d = cnt_q - CW'(1);
            default: ;
         endcase
      end
      empty_d = (cnt_d == '0);
   end

   always_ff @(posedge clk_i) begin
      if (push) mem_q[wptr_q] <= push_data;
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q    <= ST_IDLE;
         addr_q     <= '0;
         len_q      <= '0;
         issued_q   <= '0;
         tmo_q      <= '0;
         wr_en_q    <= 1'b0;
         rd_en_q    <= 1'b0;
         bus_addr_q <= '0;
         wr_data_q  <= '0;
         wptr_q     <= '0;
         rptr_q     <= '0;
         cnt_q      <= '0;
         rd_data_q  <= '0;
         empty_q    <= 1'b1;
         err_to_q   <= 1'b0;
         err_uf_q   <= 1'b0;
      end else begin
         state_q    <= state_d;
         addr_q     <= addr_d;
         len_q      <= len_d;
         issued_q   <= issued_d;
         tmo_q      <= tmo_d;
         wr_en_q    <= wr_en_d;
         rd_en_q    <= rd_en_d;
         bus_addr_q <= bus_addr_d;
         wr_data_q  <= wr_data_d;
         wptr_q     <= wptr_d;
         rptr_q     <= rptr_d;
         cnt_q      <= cnt_d;
         rd_data_q  <= rd_data_d;
         empty_q    <= empty_d;
         err_to_q   <= err_to_d;
         err_uf_q   <= err_uf_d;
      end
   end

   assign frm_rd_data_o   = rd_data_q;
   assign frm_rd_empty_o  = empty_q;
   assign bus_wr_en_o     = wr_en_q;
   assign bus_rd_en_o     = rd_en_q;
   assign bus_addr_o      = bus_addr_q;
   assign bus_wr_data_o   = wr_data_q;
   assign busy_o          = (state_q != ST_IDLE);
   assign err_timeout_o   = err_to_q;
   assign err_underflow_o = err_uf_q;

endmodule

// File: tb/tb_spi_slave_bus_bridge.sv
// tb/tb_spi_slave_bus_bridge.sv - self-checking bench for spi_slave_bus_bridge
// Randomized bursts checked against a queue-based model of the bridge's rules.
module tb_spi_slave_bus_bridge;

   localparam int DW = 32;
   localparam int AW = 16;
   localparam int CW = 8;
   localparam int STEP = 4;
   localparam int DEPTH = 4;
   localparam int TMO = 10;
   localparam logic [DW-1:0] FILL = 32'hDEAD_BEEF;

   logic          clk = 1'b0;
   logic          rst_i = 1'b1;
   logic          frm_start_i = 1'b0;
   logic [CW-1:0] frm_cmd_i = '0;
   logic [AW-1:0] frm_addr_i = '0;
   logic          frm_wr_vld_i = 1'b0;
   logic [DW-1:0] frm_wr_data_i = '0;
   logic          frm_rd_seq_i = 1'b0;
   logic [DW-1:0] frm_rd_data_o;
   logic          frm_rd_empty_o;
   logic          bus_wr_en_o;
   logic          bus_rd_en_o;
   logic [AW-1:0] bus_addr_o;
   logic [DW-1:0] bus_wr_data_o;
   logic          bus_rd_vld_i = 1'b0;
   logic [DW-1:0] bus_rd_data_i = '0;
   logic          busy_o;
   logic          err_timeout_o;
   logic          err_underflow_o;
   logic          err_clr_i = 1'b0;

   always #5 clk = ~clk;

   spi_slave_bus_bridge #(
      .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .CMD_WIDTH(CW), .ADDR_STEP(STEP),
      .FIFO_DEPTH(DEPTH), .RD_TIMEOUT(TMO), .FILL_DATA(FILL)
   ) dut (
      .clk_i(clk), .rst_i(rst_i),
      .frm_start_i(frm_start_i), .frm_cmd_i(frm_cmd_i), .frm_addr_i(frm_addr_i),
      .frm_wr_vld_i(frm_wr_vld_i), .frm_wr_data_i(frm_wr_data_i),
      .frm_rd_seq_i(frm_rd_seq_i), .frm_rd_data_o(frm_rd_data_o), .frm_rd_empty_o(frm_rd_empty_o),
      .bus_wr_en_o(bus_wr_en_o), .bus_rd_en_o(bus_rd_en_o), .bus_addr_o(bus_addr_o),
      .bus_wr_data_o(bus_wr_data_o), .bus_rd_vld_i(bus_rd_vld_i), .bus_rd_data_i(bus_rd_data_i),
      .busy_o(busy_o), .err_timeout_o(err_timeout_o), .err_underflow_o(err_underflow_o),
      .err_clr_i(err_clr_i)
   );

   int checks = 0;
   int errors = 0;

   // Model: words the bridge should hold, in order, plus the expected read-strobe sequence.
   logic [DW-1:0] exp_q[$];
   int            rd_n, rd_issued, rsp_wait, rsp_delay;
   bit            rsp_en;
   logic [AW-1:0] rd_base;

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic start(input logic [CW-1:0] cmd, input logic [AW-1:0] addr);
      frm_start_i = 1'b1;
      frm_cmd_i   = cmd;
      frm_addr_i  = addr;
      cyc();
      frm_start_i = 1'b0;
   endtask

   task automatic begin_read(input int n, input logic [AW-1:0] base, input int delay, input bit en);
      rd_n = n; rd_base = base; rd_issued = 0; rsp_delay = delay; rsp_wait = -1; rsp_en = en;
      exp_q.delete();
      start({1'b1, 7'(n - 1)}, base);
   endtask

   // Register-bus responder; every strobe must be the next word of the burst, and no more than rd_n.
   task automatic bus_cycles(input int n);
      logic [AW-1:0] ea;
      for (int t = 0; t < n; t++) begin
         bus_rd_vld_i = 1'b0;
         if (rsp_en && rsp_wait == 0) begin
            bus_rd_vld_i  = 1'b1;
            bus_rd_data_i = $urandom;
            exp_q.push_back(bus_rd_data_i);
            rsp_wait = -1;
         end else if (rsp_wait > 0) begin
            rsp_wait--;
         end
         cyc();
         bus_rd_vld_i = 1'b0;
         if (bus_rd_en_o) begin
            ea = AW'(rd_base + rd_issued * STEP);
            checks++;
            if (rd_issued >= rd_n || bus_addr_o !== ea) begin
               errors++;
               $display("FAIL rd_strobe idx %0d of %0d addr got %h want %h", rd_issued, rd_n, bus_addr_o, ea);
            end
            rd_issued++;
            rsp_wait = rsp_delay - 1;
         end
      end
   endtask

   task automatic pop_word(input string tag);
      logic [DW-1:0] e;
      e = (exp_q.size() > 0) ? exp_q.pop_front() : FILL;
      frm_rd_seq_i = 1'b1;
      cyc();
      frm_rd_seq_i = 1'b0;
      checks++;
      if (frm_rd_data_o !== e) begin
         errors++;
         $display("FAIL %s pop data got %h want %h", tag, frm_rd_data_o, e);
      end
   endtask

   task automatic test_reset();
      rst_i = 1'b1;
      cyc(); cyc();
      checks++;
      if ({busy_o, bus_wr_en_o, bus_rd_en_o, err_timeout_o, err_underflow_o, frm_rd_empty_o} !== 6'b000001) begin
         errors++;
         $display("FAIL reset_flags got %b want 000001",
                  {busy_o, bus_wr_en_o, bus_rd_en_o, err_timeout_o, err_underflow_o, frm_rd_empty_o});
      end
      checks++;
      if ({bus_addr_o, bus_wr_data_o, frm_rd_data_o} !== '0) begin
         errors++;
         $display("FAIL reset_data got %h/%h/%h want 0", bus_addr_o, bus_wr_data_o, frm_rd_data_o);
      end
      rst_i = 1'b0;
      cyc();
   endtask

   task automatic test_write_burst(input logic [CW-1:0] cmd, input logic [AW-1:0] base, input int nw);
      logic [DW-1:0] d;
      logic [AW-1:0] ea;
      int            gap;
      start(cmd, base);
      checks++;
      if (busy_o !== 1'b1) begin errors++; $display("FAIL wr_busy got %b want 1", busy_o); end
      for (int k = 0; k < nw; k++) begin
         d = $urandom;
         ea = AW'(base + k * STEP);
         frm_wr_vld_i = 1'b1;
         frm_wr_data_i = d;
         cyc();
         frm_wr_vld_i = 1'b0;
         checks++;
         if (bus_wr_en_o !== 1'b1 || bus_addr_o !== ea || bus_wr_data_o !== d) begin
            errors++;
            $display("FAIL wr_word %0d en %b addr %h data %h want 1 %h %h", k, bus_wr_en_o, bus_addr_o, bus_wr_data_o, ea, d);
         end
         gap = $urandom_range(0, 2);
         for (int g = 0; g < gap; g++) begin
            cyc();
            checks++;
            if (bus_wr_en_o !== 1'b0) begin errors++; $display("FAIL wr_idle en got %b want 0", bus_wr_en_o); end
         end
      end
   endtask

   task automatic test_read_burst(input int n, input logic [AW-1:0] base, input int delay);
      begin_read(n, base, delay, 1'b1);
      for (int t = 0; t < 200 && exp_q.size() < n; t++) bus_cycles(1);
      checks++;
      if (exp_q.size() != n || rd_issued != n) begin
         errors++;
         $display("FAIL rd_complete pushed %0d strobes %0d want %0d", exp_q.size(), rd_issued, n);
      end
      checks++;
      if (busy_o !== 1'b0) begin errors++; $display("FAIL rd_busy_fall got %b want 0", busy_o); end
      checks++;
      if (frm_rd_empty_o !== 1'b0) begin errors++; $display("FAIL rd_not_empty got %b want 0", frm_rd_empty_o); end
      bus_cycles(5);
      for (int k = 0; k < n; k++) pop_word("rd_burst");
      checks++;
      if (frm_rd_empty_o !== 1'b1) begin errors++; $display("FAIL rd_empty_after got %b want 1", frm_rd_empty_o); end
   endtask

   task automatic test_flow_control();
      begin_read(8, 16'($urandom), 1, 1'b1);
      bus_cycles(40);
      checks++;
      if (rd_issued != DEPTH || busy_o !== 1'b1) begin
         errors++;
         $display("FAIL flow_stall strobes %0d busy %b want %0d 1", rd_issued, busy_o, DEPTH);
      end
      for (int i = 0; i < 4; i++) begin
         pop_word("flow");
         bus_cycles(15);
         checks++;
         if (rd_issued != DEPTH + 1 + i) begin
            errors++;
            $display("FAIL flow_release strobes %0d want %0d", rd_issued, DEPTH + 1 + i);
         end
      end
      checks++;
      if (busy_o !== 1'b0) begin errors++; $display("FAIL flow_done busy got %b want 0", busy_o); end
      for (int k = 0; k < 4; k++) pop_word("flow_drain");
      checks++;
      if (frm_rd_empty_o !== 1'b1) begin errors++; $display("FAIL flow_empty got %b want 1", frm_rd_empty_o); end
   endtask

   task automatic test_timeout();
      begin_read(2, 16'($urandom), 1, 1'b0);
      for (int t = 0; t < 5 && rd_issued == 0; t++) bus_cycles(1);
      bus_cycles(TMO - 1);
      checks++;
      if (err_timeout_o !== 1'b0) begin errors++; $display("FAIL tmo_early got %b want 0", err_timeout_o); end
      bus_cycles(1);
      exp_q.push_back(FILL);
      checks++;
      if (err_timeout_o !== 1'b1 || frm_rd_empty_o !== 1'b0) begin
         errors++;
         $display("FAIL tmo_fire err %b empty %b want 1 0", err_timeout_o, frm_rd_empty_o);
      end
      bus_cycles(1);
      checks++;
      if (rd_issued != 2) begin errors++; $display("FAIL tmo_reissue strobes %0d want 2", rd_issued); end
      bus_cycles(TMO);
      exp_q.push_back(FILL);
      checks++;
      if (busy_o !== 1'b0) begin errors++; $display("FAIL tmo_done busy got %b want 0", busy_o); end
      pop_word("tmo");
      pop_word("tmo");
      err_clr_i = 1'b1;
      cyc();
      err_clr_i = 1'b0;
      checks++;
      if (err_timeout_o !== 1'b0) begin errors++; $display("FAIL tmo_clear got %b want 0", err_timeout_o); end
   endtask

   task automatic test_underflow_wrap();
      exp_q.delete();
      pop_word("underflow");
      checks++;
      if (err_underflow_o !== 1'b1 || frm_rd_empty_o !== 1'b1) begin
         errors++;
         $display("FAIL uf_flag err %b empty %b want 1 1", err_underflow_o, frm_rd_empty_o);
      end
      err_clr_i = 1'b1;
      cyc();
      checks++;
      if (err_underflow_o !== 1'b0) begin errors++; $display("FAIL uf_clear got %b want 0", err_underflow_o); end
      pop_word("uf_with_clr");
      err_clr_i = 1'b0;
      checks++;
      if (err_underflow_o !== 1'b1) begin errors++; $display("FAIL uf_set_wins got %b want 1", err_underflow_o); end
      err_clr_i = 1'b1;
      cyc();
      err_clr_i = 1'b0;
      test_write_burst(8'h01, 16'hFFFC, 2);
   endtask

   task automatic test_abort();
      logic [AW-1:0] nb;
      logic [DW-1:0] d;
      begin_read(8, 16'($urandom), 3, 1'b1);
      for (int t = 0; t < 100 && rd_issued < 3; t++) bus_cycles(1);
      rsp_en = 1'b0;
      rsp_wait = -1;
      rd_n = rd_issued;
      nb = 16'($urandom);
      start(8'h05, nb);
      checks++;
      if (frm_rd_empty_o !== 1'b1 || busy_o !== 1'b1) begin
         errors++;
         $display("FAIL abort_flush empty %b busy %b want 1 1", frm_rd_empty_o, busy_o);
      end
      bus_rd_vld_i = 1'b1;
      bus_rd_data_i = $urandom;
      cyc();
      bus_rd_vld_i = 1'b0;
      bus_cycles(15);
      checks++;
      if (frm_rd_empty_o !== 1'b1) begin errors++; $display("FAIL abort_late_vld empty got %b want 1", frm_rd_empty_o); end
      d = $urandom;
      frm_wr_vld_i = 1'b1;
      frm_wr_data_i = d;
      cyc();
      frm_wr_vld_i = 1'b0;
      checks++;
      if (bus_wr_en_o !== 1'b1 || bus_addr_o !== nb || bus_wr_data_o !== d) begin
         errors++;
         $display("FAIL abort_new_write en %b addr %h data %h want 1 %h %h", bus_wr_en_o, bus_addr_o, bus_wr_data_o, nb, d);
      end
   endtask

   task automatic test_reset_mid_burst();
      begin_read(4, 16'($urandom), 4, 1'b1);
      for (int t = 0; t < 10 && rd_issued == 0; t++) bus_cycles(1);
      rst_i = 1'b1;
      cyc();
      rst_i = 1'b0;
      checks++;
      if ({busy_o, bus_wr_en_o, bus_rd_en_o, err_timeout_o, err_underflow_o, frm_rd_empty_o} !== 6'b000001
          || bus_addr_o !== '0) begin
         errors++;
         $display("FAIL midrst_state flags %b addr %h want 000001 0",
                  {busy_o, bus_wr_en_o, bus_rd_en_o, err_timeout_o, err_underflow_o, frm_rd_empty_o}, bus_addr_o);
      end
      rsp_en = 1'b0;
      rd_n = rd_issued;
      bus_cycles(20);
      checks++;
      if (busy_o !== 1'b0 || frm_rd_empty_o !== 1'b1) begin
         errors++;
         $display("FAIL midrst_quiet busy %b empty %b want 0 1", busy_o, frm_rd_empty_o);
      end
   endtask

   initial begin
      rd_n = 0; rd_issued = 0; rsp_wait = -1; rsp_delay = 1; rsp_en = 1'b0; rd_base = '0;
      test_reset();
      test_write_burst(8'h02, 16'h0100, 3);
      test_write_burst(8'h00, 16'($urandom), 5);
      test_write_burst(CW'($urandom), 16'($urandom), 4);
      test_read_burst(4, 16'h0200, 2);
      test_read_burst($urandom_range(1, 4), 16'($urandom), $urandom_range(1, 4));
      test_read_burst($urandom_range(1, 4), 16'hFFF8, $urandom_range(1, 4));
      test_flow_control();
      test_timeout();
      test_underflow_wrap();
      test_abort();
      test_reset_mid_burst();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
